// File: rtl/elastic_pipeline_stage.sv
// Elastic DEPTH-entry valid/ready stage with synchronous flush and output bubble.
// Optional back-pressure counter is built when ELASTIC_STAGE_STALL_CNT_EN is defined.
module elastic_pipeline_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         global_flush_i,
  input  logic                         bubble_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [WIDTH-1:0]             data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [31:0]                  stall_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_p0 [DEPTH];
  logic [PTR_W-1:0] wr_ptr_p0;
  logic [PTR_W-1:0] rd_ptr_p0;
  logic [CNT_W-1:0] count_p0;
  logic             vld_p0;
  logic             flush;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign flush   = flush_i | global_flush_i;
  assign ready_o = (count_p0 < FULL_CNT);
  assign vld_p0  = (count_p0 != '0) && !bubble_i;
  assign push    = valid_i && ready_o;
  assign pop     = vld_p0 && ready_i;
  assign valid_o = vld_p0;
  assign data_o  = vld_p0 ? mem_p0[rd_ptr_p0] : '0;
  assign count_o = count_p0;

  // ---- stage p0: control state ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      count_p0  <= '0;
    end else if (flush) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      count_p0  <= '0;
    end else begin
      if (push) wr_ptr_p0 <= ptr_inc(wr_ptr_p0);
      if (pop)  rd_ptr_p0 <= ptr_inc(rd_ptr_p0);
      case ({push, pop})
        2'b10:   count_p0 <= count_p0 + 1'b1;
        2'b01:   count_p0 <= count_p0 - 1'b1;
        default: count_p0 <= count_p0;
      endcase
    end
  end

  // ---- stage p0: payload storage ----
  always_ff @(posedge clk) begin
    if (push && !flush) mem_p0[wr_ptr_p0] <= data_i;
  end

`ifdef ELASTIC_STAGE_STALL_CNT_EN
  logic [31:0] stall_cnt_p0;

  // Flushes deliberately leave the counter alone; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_p0 <= '0;
    end else if (vld_p0 && !ready_i) begin
      stall_cnt_p0 <= sat_inc(stall_cnt_p0);
    end
  end

  assign stall_cnt_o = stall_cnt_p0;
`else
  assign stall_cnt_o = 32'd0;
`endif

endmodule
